// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state and owner encodings shared by the memory controller
package mem_ctrl_pkg;
  typedef enum logic [1:0] {MC_IDLE, MC_RD, MC_WR, MC_DONE} mc_state_t;
  typedef enum logic {OWN_IF, OWN_LSB} mc_owner_t;
  localparam logic [1:0] IF_LEN = 2'd3;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch/LSB accesses onto the byte-wide RAM bus; MC_IO_STALL_EN holds IO writes while io_buffer_full
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_HI_BIT = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              inst_MC_req,
  input  logic [ADDR_W-1:0] inst_MC_addr,
  output logic              inst_MC_flag,
  output logic [31:0]       inst_MC,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_len,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        mem_din,
  input  logic              io_buffer_full,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  mc_state_t         state, state_n;
  mc_owner_t         owner;
  logic [2:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        len, idx;
  logic [31:0]       wdata, word;
  logic [7:0]        byte_q [4];
  logic              wr_q, go, latch_lsb, latch_if, idle_hold, wr_hold, done_in, own_lsb;

`ifdef MC_IO_STALL_EN
  assign idle_hold = io_buffer_full && lsb_wr && lsb_addr[IO_HI_BIT -: 2] == 2'b11;
  assign wr_hold = io_buffer_full && addr[IO_HI_BIT -: 2] == 2'b11;
`else
  logic unused_full;
  assign unused_full = io_buffer_full;
  assign idle_hold = 1'b0;
  assign wr_hold = 1'b0;
`endif

  assign go = rdy && !rst;
  assign done_in = state_n == MC_DONE && state != MC_DONE;
  assign own_lsb = latch_lsb || owner == OWN_LSB;

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mem_a = '0;
    mem_wr = 1'b0;
    mem_dout = '0;
    latch_lsb = 1'b0;
    latch_if = 1'b0;
    idx = '0;
    word = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
    case (state)
      MC_IDLE:
        if (go && lsb_req && !idle_hold) begin
          latch_lsb = 1'b1;
          mem_a = lsb_addr;
          mem_wr = lsb_wr;
          mem_dout = lsb_wr ? lsb_wdata[7:0] : '0;
          state_n = !lsb_wr ? MC_RD : lsb_len == 2'd0 ? MC_DONE : MC_WR;
          cnt_n = lsb_wr && lsb_len == 2'd0 ? 3'd0 : 3'd1;
        end else if (go && inst_MC_req && !lsb_req) begin
          latch_if = 1'b1;
          mem_a = inst_MC_addr;
          state_n = MC_RD;
          cnt_n = 3'd1;
        end
      MC_RD: begin
        idx = cnt[1:0] - 2'd1;
        word[{idx, 3'b000} +: 8] = mem_din;
        // while frozen, re-present the byte still owed so mem_din is valid on resume
        mem_a = !rdy ? addr + ADDR_W'(cnt - 3'd1)
              : cnt <= {1'b0, len} ? addr + ADDR_W'(cnt) : '0;
        state_n = cnt == {1'b0, len} + 3'd1 ? MC_DONE : MC_RD;
        cnt_n = cnt == {1'b0, len} + 3'd1 ? 3'd0 : cnt + 3'd1;
      end
      MC_WR:
        if (!wr_hold) begin
          mem_wr = 1'b1;
          mem_a = addr + ADDR_W'(cnt);
          mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
          state_n = cnt[1:0] == len ? MC_DONE : MC_WR;
          cnt_n = cnt[1:0] == len ? 3'd0 : cnt + 3'd1;
        end
      default: begin
        state_n = MC_IDLE;
        cnt_n = '0;
      end
    endcase
    mem_wr = mem_wr && go;
    mem_a = rst ? '0 : mem_a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      cnt <= '0;
      owner <= OWN_IF;
      addr <= '0;
      len <= '0;
      wdata <= '0;
      wr_q <= 1'b0;
      byte_q <= '{default: '0};
      inst_MC_flag <= 1'b0;
      lsb_done <= 1'b0;
      inst_MC <= '0;
      lsb_rdata <= '0;
    end else if (rdy) begin
      state <= state_n;
      cnt <= cnt_n;
      if (latch_lsb || latch_if) begin
        addr <= latch_lsb ? lsb_addr : inst_MC_addr;
        len <= latch_lsb ? lsb_len : IF_LEN;
        wdata <= latch_lsb ? lsb_wdata : '0;
        wr_q <= latch_lsb && lsb_wr;
        owner <= latch_lsb ? OWN_LSB : OWN_IF;
        byte_q <= '{default: '0};
      end
      if (state == MC_RD) byte_q[idx] <= mem_din;
      inst_MC_flag <= done_in && !own_lsb;
      lsb_done <= done_in && own_lsb;
      if (done_in && !own_lsb) inst_MC <= word;
      if (done_in && own_lsb) lsb_rdata <= (latch_lsb || wr_q) ? '0 : word;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven + scoreboard bench for mem_ctrl against a byte-wide RAM model
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        inst_MC_req, inst_MC_flag, lsb_req, lsb_wr, lsb_done, io_buffer_full, mem_wr;
  logic [31:0] inst_MC_addr, inst_MC, lsb_addr, lsb_wdata, lsb_rdata, mem_a;
  logic [1:0]  lsb_len;
  logic [7:0]  mem_din, mem_dout;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .inst_MC_req(inst_MC_req), .inst_MC_addr(inst_MC_addr),
    .inst_MC_flag(inst_MC_flag), .inst_MC(inst_MC),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    bit          chk;
    logic [31:0] data;
    int          lat;
    int          t0;
  } exp_t;

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic [7:0] ram [logic [31:0]];
  exp_t sb[$];
  exp_t e;
  vec_t vt[13];
  int n_cmp = 0, n_bad = 0, cyc = 0, wr_cnt = 0, w0;
  bit ok;

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (mem_wr) begin
      wr_cnt++;
      ram[mem_a] = mem_dout;
    end
    mem_din <= rd(mem_a);
  end

  always @(negedge clk)
    if (!rst && (inst_MC_flag || lsb_done)) begin
      if (inst_MC_flag && lsb_done) chk("both_flags", 32'd1, 32'd0);
      if (sb.size() == 0) chk("spurious_flag", {30'd0, inst_MC_flag, lsb_done}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("owner_if", {31'd0, inst_MC_flag}, {31'd0, e.is_if});
        if (e.chk) chk("rdata", inst_MC_flag ? inst_MC : lsb_rdata, e.data);
        chk("latency", cyc - e.t0, e.lat);
      end
    end

  task automatic wait_flag(input bit is_if);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = is_if ? inst_MC_flag : lsb_done;
    end
    if (!ok) chk(is_if ? "timeout_if" : "timeout_lsb", 32'd0, 32'd1);
  endtask

  task automatic do_vec(input vec_t v);
    @(negedge clk);
    w0 = wr_cnt;
    if (v.is_if) begin
      inst_MC_addr = v.addr;
      inst_MC_req = 1'b1;
    end else begin
      lsb_wr = v.wr;
      lsb_len = v.len;
      lsb_addr = v.addr;
      lsb_wdata = v.wdata;
      lsb_req = 1'b1;
    end
    sb.push_back('{v.is_if, !v.wr, v.exp, v.lat, cyc});
    wait_flag(v.is_if);
    inst_MC_req = 1'b0;
    lsb_req = 1'b0;
    chk("write_count", wr_cnt - w0, v.wr ? 32'(v.len) + 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; inst_MC_req = 1'b0; inst_MC_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_len = '0; lsb_addr = '0; lsb_wdata = '0;
    io_buffer_full = 1'b0;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h2000] = 8'h11; ram[32'h2001] = 8'h22; ram[32'h2002] = 8'h33; ram[32'h2003] = 8'hFF;
    vt[0]  = '{1, 0, 2'd3, 32'h1000, 32'h0, 32'h00000513, 5};
    vt[1]  = '{0, 0, 2'd0, 32'h2003, 32'h0, 32'h000000FF, 2};
    vt[2]  = '{0, 0, 2'd1, 32'h2001, 32'h0, 32'h00003322, 3};
    vt[3]  = '{0, 0, 2'd3, 32'h2000, 32'h0, 32'hFF332211, 5};
    vt[4]  = '{0, 1, 2'd3, 32'h40, 32'hDEADBEEF, 32'h0, 4};
    vt[5]  = '{0, 0, 2'd3, 32'h40, 32'h0, 32'hDEADBEEF, 5};
    vt[6]  = '{0, 1, 2'd0, 32'h50, 32'h123456AB, 32'h0, 1};
    vt[7]  = '{0, 0, 2'd3, 32'h50, 32'h0, 32'h000000AB, 5};
    vt[8]  = '{0, 1, 2'd1, 32'h60, 32'hCAFE1234, 32'h0, 2};
    vt[9]  = '{1, 0, 2'd3, 32'h60, 32'h0, 32'h00001234, 5};
    vt[10] = '{0, 1, 2'd3, 32'hFFFFFFFE, 32'hA1B2C3D4, 32'h0, 4};
    vt[11] = '{0, 0, 2'd3, 32'hFFFFFFFE, 32'h0, 32'hA1B2C3D4, 5};
    vt[12] = '{1, 0, 2'd3, 32'h2000, 32'h0, 32'hFF332211, 5};
    repeat (3) @(negedge clk);
    chk("rst_inst_flag", {31'd0, inst_MC_flag}, 32'd0);
    chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    chk("rst_inst_MC", inst_MC, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    rst = 1'b0;

    foreach (vt[i]) do_vec(vt[i]);
    chk("ram_40", {24'd0, rd(32'h40)}, 32'hEF);
    chk("ram_41", {24'd0, rd(32'h41)}, 32'hBE);
    chk("ram_42", {24'd0, rd(32'h42)}, 32'hAD);
    chk("ram_43", {24'd0, rd(32'h43)}, 32'hDE);
    chk("ram_wrap_0", {24'd0, rd(32'h0)}, 32'hB2);
    chk("ram_wrap_1", {24'd0, rd(32'h1)}, 32'hA1);

    // simultaneous requests: LSB byte load first, fetch follows after DONE+IDLE
    @(negedge clk);
    lsb_wr = 1'b0; lsb_len = 2'd0; lsb_addr = 32'h2003; lsb_req = 1'b1;
    inst_MC_addr = 32'h1000; inst_MC_req = 1'b1;
    sb.push_back('{0, 1, 32'h000000FF, 2, cyc});
    sb.push_back('{1, 1, 32'h00000513, 8, cyc});
    wait_flag(1'b0);
    lsb_req = 1'b0;
    wait_flag(1'b1);
    inst_MC_req = 1'b0;

    // rdy low for 3 cycles in the middle of a word fetch
    @(negedge clk);
    w0 = wr_cnt;
    inst_MC_addr = 32'h2000; inst_MC_req = 1'b1;
    sb.push_back('{1, 1, 32'hFF332211, 8, cyc});
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    rdy = 1'b1;
    wait_flag(1'b1);
    inst_MC_req = 1'b0;
    chk("rdy_no_write", wr_cnt - w0, 32'd0);

    // IO-space store with the IO buffer full
    @(negedge clk);
    w0 = wr_cnt;
    io_buffer_full = 1'b1;
    lsb_wr = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h5A; lsb_req = 1'b1;
`ifdef MC_IO_STALL_EN
    sb.push_back('{0, 0, 32'h0, 5, cyc});
    repeat (4) begin
      @(negedge clk);
      chk("io_stall_mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    chk("io_stall_count", wr_cnt - w0, 32'd0);
    io_buffer_full = 1'b0;
    wait_flag(1'b0);
`else
    sb.push_back('{0, 0, 32'h0, 1, cyc});
    wait_flag(1'b0);
    io_buffer_full = 1'b0;
`endif
    lsb_req = 1'b0;
    chk("io_write_count", wr_cnt - w0, 32'd1);
    chk("io_ram", {24'd0, rd(32'h30000)}, 32'h5A);

    // reset in the middle of a fetch aborts it with no flag
    @(negedge clk);
    inst_MC_addr = 32'h1000; inst_MC_req = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_a", mem_a, 32'd0);
    chk("midrst_inst_MC", inst_MC, 32'd0);
    chk("midrst_flag", {31'd0, inst_MC_flag}, 32'd0);
    inst_MC_req = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
